// File: rtl/fetch_seq.sv
// fetch_seq: byte-serial Y86-64 instruction fetch sequencer.
// Owns the PC and reads one instruction byte per memory handshake.
// It assembles icode/ifun/rA/rB/valC/valP, presents the result to decode,
// and handles redirects, halt, invalid opcodes and memory faults.
module fetch_seq #(
  parameter int                  DATA_WID = 64,
  parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  // instruction memory port
  output logic                mem_req,
  output logic [DATA_WID-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_err,
  // redirect from later stages
  input  logic                pc_load,
  input  logic [DATA_WID-1:0] pc_new,
  // decoded instruction towards decode
  output logic [3:0]          icode,
  output logic [3:0]          ifun,
  output logic [3:0]          rA,
  output logic [3:0]          rB,
  output logic [DATA_WID-1:0] valC,
  output logic [DATA_WID-1:0] valP,
  output logic [DATA_WID-1:0] pc_out,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic                instr_bad,
  output logic                imem_error,
  output logic                halted
);

  localparam logic [2:0] S_FETCH_OP  = 3'd0;
  localparam logic [2:0] S_FETCH_REG = 3'd1;
  localparam logic [2:0] S_FETCH_C   = 3'd2;
  localparam logic [2:0] S_PRESENT   = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  // Instruction classes that carry a register-specifier byte.
  function automatic logic dec_need_regids(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: dec_need_regids = 1'b1;
      default:                                  dec_need_regids = 1'b0;
    endcase
  endfunction

  // Instruction classes that carry an 8-byte constant.
  function automatic logic dec_need_valc(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: dec_need_valc = 1'b1;
      default:                      dec_need_valc = 1'b0;
    endcase
  endfunction

  logic [2:0]          state;
  logic [DATA_WID-1:0] pc;
  logic [2:0]          cnt;          // valC byte index k
  logic                need_regids;
  logic                need_valc;
  logic [3:0]          icode_r, ifun_r, ra_r, rb_r;
  logic [DATA_WID-1:0] valc_r, valp_r, pc_out_r;
  logic                bad_r, err_r;

  // Opcode decode of the byte currently on the bus (used only in FETCH_OP).
  logic [3:0]          op_icode;
  logic                op_nr, op_nc;
  logic [DATA_WID-1:0] op_valp;

  // Decode the opcode byte and precompute the sequential successor.
  always_comb begin
    op_icode = mem_rdata[7:4];
    op_nr    = dec_need_regids(op_icode);
    op_nc    = dec_need_valc(op_icode);
    op_valp  = pc + DATA_WID'(1) + DATA_WID'(op_nr) + (op_nc ? DATA_WID'(8) : DATA_WID'(0));
  end

  // Memory request and address: only the three fetch states talk to memory.
  // The address is a pure function of registered state, so it holds steady
  // through wait states.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = pc;
    case (state)
      S_FETCH_OP: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_FETCH_REG: begin
        mem_req  = 1'b1;
        mem_addr = pc + DATA_WID'(1);
      end
      S_FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = pc + DATA_WID'(1) + DATA_WID'(need_regids) + DATA_WID'(cnt);
      end
      default: begin
        mem_req  = 1'b0;
        mem_addr = pc;
      end
    endcase
  end

  // Sequencer state, PC and captured instruction fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH_OP;
      pc          <= RESET_PC;
      cnt         <= '0;
      need_regids <= 1'b0;
      need_valc   <= 1'b0;
      icode_r     <= '0;
      ifun_r      <= '0;
      ra_r        <= '0;
      rb_r        <= '0;
      valc_r      <= '0;
      valp_r      <= '0;
      pc_out_r    <= '0;
      bad_r       <= 1'b0;
      err_r       <= 1'b0;
    end else if (pc_load) begin
      // Redirect wins over any ack or decode handshake in the same cycle.
      state <= S_FETCH_OP;
      pc    <= pc_new;
      cnt   <= '0;
      bad_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (state)
        S_FETCH_OP: begin
          if (mem_ack) begin
            // Unfetched fields read as "no register" / zero constant.
            ra_r     <= 4'hF;
            rb_r     <= 4'hF;
            valc_r   <= '0;
            pc_out_r <= pc;
            cnt      <= '0;
            if (mem_err) begin
              // Faulted opcode byte: nothing trustworthy was read.
              icode_r     <= '0;
              ifun_r      <= '0;
              need_regids <= 1'b0;
              need_valc   <= 1'b0;
              valp_r      <= pc + DATA_WID'(1);
              bad_r       <= 1'b0;
              err_r       <= 1'b1;
              state       <= S_PRESENT;
            end else begin
              icode_r     <= op_icode;
              ifun_r      <= mem_rdata[3:0];
              need_regids <= op_nr;
              need_valc   <= op_nc;
              valp_r      <= op_valp;
              bad_r       <= (op_icode > 4'hB);
              err_r       <= 1'b0;
              if (op_nr)      state <= S_FETCH_REG;
              else if (op_nc) state <= S_FETCH_C;
              else            state <= S_PRESENT;
            end
          end
        end
        S_FETCH_REG: begin
          if (mem_ack) begin
            if (mem_err) begin
              err_r <= 1'b1;
              state <= S_PRESENT;
            end else begin
              ra_r  <= mem_rdata[7:4];
              rb_r  <= mem_rdata[3:0];
              state <= need_valc ? S_FETCH_C : S_PRESENT;
            end
          end
        end
        S_FETCH_C: begin
          if (mem_ack) begin
            if (mem_err) begin
              err_r <= 1'b1;
              state <= S_PRESENT;
            end else begin
              // Little-endian: byte k lands in valC[8k+7:8k].
              valc_r[{cnt, 3'b000} +: 8] <= mem_rdata;
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) state <= S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          if (instr_ready) begin
            if (icode_r == 4'h0 || bad_r || err_r) begin
              state <= S_HALTED;
            end else begin
              pc    <= valp_r;
              state <= S_FETCH_OP;
            end
          end
        end
        S_HALTED: begin
          // Only a redirect (handled above) leaves this state.
          state <= S_HALTED;
        end
        default: begin
          state <= S_FETCH_OP;
        end
      endcase
    end
  end

  assign icode       = icode_r;
  assign ifun        = ifun_r;
  assign rA          = ra_r;
  assign rB          = rb_r;
  assign valC        = valc_r;
  assign valP        = valp_r;
  assign pc_out      = pc_out_r;
  assign instr_bad   = bad_r;
  assign imem_error  = err_r;
  assign instr_valid = (state == S_PRESENT);
  assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: table vectors, hand-written corner sequences and a
// randomized run against an instruction-level reference model.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack, mem_err;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        pc_load;
  logic [63:0] pc_new;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, pc_out;
  logic        instr_valid, instr_ready, instr_bad, imem_error, halted;

  always #5 clk = ~clk;

  fetch_seq #(.DATA_WID(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .pc_load(pc_load), .pc_new(pc_new),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_bad(instr_bad), .imem_error(imem_error), .halted(halted)
  );

  // 256-byte memory image aliased over the whole address space.
  logic [7:0]  mem [256];
  int          max_wait = 0;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [63:0] err_addr = '0;

  assign mem_ack   = mem_req && (wcnt == 0);
  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_err   = err_en && (mem_addr == err_addr);

  // Wait-state generator: random latency per byte when max_wait > 0.
  always @(posedge clk) begin
    if (max_wait == 0)               wcnt <= 0;
    else if (!mem_req || mem_ack)    wcnt <= int'($urandom_range(0, max_wait));
    else                             wcnt <= wcnt - 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] a);
    pc_load = 1'b1;
    pc_new  = a;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!instr_valid) chk("timeout_valid", 64'd0, 64'd1);
  endtask

  // Reference model: whole-instruction view from the Y86 encoding rules.
  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        bad, stop;
  } exp_t;

  function automatic exp_t ref_decode(input logic [63:0] pc);
    exp_t        e;
    logic [7:0]  b0, rb;
    logic [63:0] a;
    logic        nr, nc;
    b0 = mem[pc[7:0]];
    e.icode = b0[7:4];
    e.ifun  = b0[3:0];
    nr = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    nc = e.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
    a  = pc + 64'd1;
    rb = nr ? mem[a[7:0]] : 8'hFF;
    e.ra = rb[7:4];
    e.rb = rb[3:0];
    e.valc = '0;
    if (nc)
      for (int k = 0; k < 8; k++) begin
        a = pc + 64'd1 + {63'd0, nr} + 64'(k);
        e.valc[8*k +: 8] = mem[a[7:0]];
      end
    e.valp = pc + 64'd1 + {63'd0, nr} + (nc ? 64'd8 : 64'd0);
    e.bad  = e.icode > 4'hB;
    e.stop = e.bad || e.icode == 4'h0;
    return e;
  endfunction

  typedef struct {
    logic [63:0] pc;
    int          n;
    logic [79:0] bytes;   // byte i at bits [8i+7:8i]
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        bad, stop;
  } vec_t;

  vec_t vt[13];

  initial begin
    int          cyc;
    logic [63:0] a;
    exp_t        e;
    logic [63:0] exp_pc;
    logic        exp_halt, pl, rdy, prev_req, prev_ack, prev_pl;
    logic [63:0] prev_addr;

    vt[0]  = '{64'h10, 1,  80'h10,                   4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                64'h11, 1'b0, 1'b0};
    vt[1]  = '{64'h20, 10, 80'h0102030405060708F330, 4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h2A, 1'b0, 1'b0};
    vt[2]  = '{64'h40, 2,  80'h1220,                 4'h2, 4'h0, 4'h1, 4'h2, 64'h0,                64'h42, 1'b0, 1'b0};
    vt[3]  = '{64'h50, 9,  80'h112233445566778870,   4'h7, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 64'h59, 1'b0, 1'b0};
    vt[4]  = '{64'h60, 9,  80'h000000000000010080,   4'h8, 4'h0, 4'hF, 4'hF, 64'h100,              64'h69, 1'b0, 1'b0};
    vt[5]  = '{64'h70, 1,  80'h90,                   4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                64'h71, 1'b0, 1'b0};
    vt[6]  = '{64'h78, 2,  80'h3FA0,                 4'hA, 4'h0, 4'h3, 4'hF, 64'h0,                64'h7A, 1'b0, 1'b0};
    vt[7]  = '{64'h80, 2,  80'h2361,                 4'h6, 4'h1, 4'h2, 4'h3, 64'h0,                64'h82, 1'b0, 1'b0};
    vt[8]  = '{64'h88, 10, 80'h00000000000000104550, 4'h5, 4'h0, 4'h4, 4'h5, 64'h10,               64'h92, 1'b0, 1'b0};
    vt[9]  = '{64'h98, 2,  80'h4521,                 4'h2, 4'h1, 4'h4, 4'h5, 64'h0,                64'h9A, 1'b0, 1'b0};
    vt[10] = '{64'hC0, 2,  80'h4FB0,                 4'hB, 4'h0, 4'h4, 4'hF, 64'h0,                64'hC2, 1'b0, 1'b0};
    vt[11] = '{64'hA0, 1,  80'hE0,                   4'hE, 4'h0, 4'hF, 4'hF, 64'h0,                64'hA1, 1'b1, 1'b1};
    vt[12] = '{64'h05, 1,  80'h00,                   4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                64'h06, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h10;
    rst = 1'b1; pc_load = 1'b0; pc_new = '0; instr_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_mem_req", 64'(mem_req), 64'd1);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_valP", valP, 64'd0);
    chk("rst_rA", 64'(rA), 64'd0);
    chk("rst_bad", 64'(instr_bad), 64'd0);
    rst = 1'b0; instr_ready = 1'b1;
    tick();
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_icode", 64'(icode), 64'd1);
    chk("first_valP", valP, 64'd1);
    chk("first_rArB", {56'd0, rA, rB}, 64'hFF);
    tick();
    chk("next_addr", mem_addr, 64'd1);
    chk("next_req", 64'(mem_req), 64'd1);
    instr_ready = 1'b0;

    // Table-driven vectors, zero-wait memory
    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        a = vt[v].pc + 64'(i);
        mem[a[7:0]] = vt[v].bytes[8*i +: 8];
      end
      redirect(vt[v].pc);
      wait_valid(cyc);
      chk($sformatf("v%0d_latency", v), 64'(cyc), 64'(vt[v].n));
      chk($sformatf("v%0d_icode", v), {52'd0, icode, ifun, rA, rB},
          {52'd0, vt[v].icode, vt[v].ifun, vt[v].ra, vt[v].rb});
      chk($sformatf("v%0d_valC", v), valC, vt[v].valc);
      chk($sformatf("v%0d_valP", v), valP, vt[v].valp);
      chk($sformatf("v%0d_pc_out", v), pc_out, vt[v].pc);
      chk($sformatf("v%0d_bad", v), 64'(instr_bad), 64'(vt[v].bad));
      for (int h = 0; h < 5; h++) begin
        tick();
        chk($sformatf("v%0d_hold", v), {62'd0, instr_valid, mem_req}, 64'd2);
        chk($sformatf("v%0d_hold_valP", v), valP, vt[v].valp);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      if (vt[v].stop) begin
        chk($sformatf("v%0d_halted", v), {61'd0, halted, mem_req, instr_valid}, 64'd4);
      end else begin
        chk($sformatf("v%0d_next_addr", v), mem_addr, vt[v].valp);
        chk($sformatf("v%0d_next_req", v), 64'(mem_req), 64'd1);
      end
    end

    // Halted stays halted until a redirect, which restarts at the target
    for (int h = 0; h < 4; h++) begin
      tick();
      chk("halt_hold", {62'd0, halted, mem_req}, 64'd2);
    end
    redirect(64'h0);
    chk("unhalt", {62'd0, halted, mem_req}, 64'd1);
    chk("unhalt_addr", mem_addr, 64'h0);

    // PC at the top of the address space: valP wraps to zero
    mem[8'hFF] = 8'h10;
    redirect(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(cyc);
    chk("wrap_valP", valP, 64'h0);
    chk("wrap_pc_out", pc_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // Memory fault on the third byte of a jXX
    mem[8'hB0] = 8'h73;
    for (int i = 1; i < 9; i++) mem[8'hB0 + i] = 8'(8'h10 * i + i);
    err_en = 1'b1; err_addr = 64'hB2;
    redirect(64'hB0);
    wait_valid(cyc);
    chk("err_flag", 64'(imem_error), 64'd1);
    chk("err_icode", {56'd0, icode, ifun}, 64'h73);
    chk("err_valC", valC, 64'h11);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    err_en = 1'b0;
    chk("err_halted", 64'(halted), 64'd1);

    // Redirect clears a presented instr_bad
    redirect(64'hA0);
    wait_valid(cyc);
    chk("bad_set", 64'(instr_bad), 64'd1);
    redirect(64'h10);
    chk("bad_clear", {62'd0, instr_bad, instr_valid}, 64'd0);
    chk("bad_redir_addr", mem_addr, 64'h10);

    // Redirect together with an accepting handshake: redirect wins
    wait_valid(cyc);
    instr_ready = 1'b1;
    redirect(64'h40);
    instr_ready = 1'b0;
    chk("ldrdy_addr", mem_addr, 64'h40);
    chk("ldrdy_valid", 64'(instr_valid), 64'd0);
    wait_valid(cyc);
    chk("ldrdy_pc_out", pc_out, 64'h40);

    // Redirect during FETCH_C k=4 with a same-cycle ack
    redirect(64'h20);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_k4_addr", mem_addr, 64'h26);
    chk("abort_k4_ack", 64'(mem_ack), 64'd1);
    redirect(64'h40);
    chk("abort_addr", mem_addr, 64'h40);
    chk("abort_valid", 64'(instr_valid), 64'd0);
    wait_valid(cyc);
    chk("abort_latency", 64'(cyc), 64'd2);
    chk("abort_icode", 64'(icode), 64'h2);
    chk("abort_valP", valP, 64'h42);

    // Reset in the middle of a fetch
    redirect(64'h20);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req_addr", {mem_addr[62:0], mem_req}, 64'd1);
    chk("midrst_fields", {55'd0, instr_valid, icode, ifun}, 64'd0);
    wait_valid(cyc);
    chk("midrst_pc_out", pc_out, 64'h0);

    // Randomized run: wait states, random ready and redirects
    for (int i = 0; i < 256; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)      mem[i] = {4'h0, 4'($urandom)};
      else if (r < 4) mem[i] = {4'(4'hC + 4'($urandom_range(0, 3))), 4'($urandom)};
      else            mem[i] = {4'($urandom_range(1, 11)), 4'($urandom)};
    end
    max_wait = 3;
    exp_pc   = {32'($urandom), 32'($urandom)};
    exp_halt = 1'b0;
    redirect(exp_pc);
    prev_req = 1'b0; prev_ack = 1'b0; prev_pl = 1'b1; prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (mem_req && prev_req && !prev_ack && !prev_pl)
        chk("rnd_addr_stable", mem_addr, prev_addr);
      chk("rnd_halted", 64'(halted), 64'(exp_halt));
      e = ref_decode(exp_pc);
      if (instr_valid) begin
        chk("rnd_pc_out", pc_out, exp_pc);
        chk("rnd_fields", {51'd0, instr_bad, icode, ifun, rA, rB},
            {51'd0, e.bad, e.icode, e.ifun, e.ra, e.rb});
        chk("rnd_valC", valC, e.valc);
        chk("rnd_valP", valP, e.valp);
      end
      pl  = exp_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      rdy = 1'($urandom_range(0, 1));
      pc_load     = pl;
      instr_ready = rdy;
      pc_new      = {32'($urandom), 32'($urandom)};
      if (pl) begin
        exp_pc   = pc_new;
        exp_halt = 1'b0;
      end else if (instr_valid && rdy) begin
        if (e.stop) exp_halt = 1'b1;
        else        exp_pc   = e.valp;
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
      prev_pl   = pl;
      tick();
    end
    pc_load = 1'b0;
    instr_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Byte-serial instruction fetch sequencer for the Y86-64 core. It owns the program counter and drives a byte-wide instruction memory port over a req/ack handshake. It fetches the variable-length instruction (1, 2, 9 or 10 bytes) at PC, assembles icode/ifun/rA/rB/valC and valP, and presents them to decode with a valid/ready handshake. It also handles PC redirects from later stages, halt, invalid opcodes and memory errors.

## Interface
- DATA_WID, 64: width of PC, valC and valP; fixed to 64 (8 valC bytes).
- RESET_PC, 0: PC value after reset.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  byte read request; held with stable mem_addr until mem_ack.
- mem_addr  out  DATA_WID  byte address.
- mem_ack  in  1  read done; mem_rdata and mem_err are valid this cycle.
- mem_rdata  in  8  read byte.
- mem_err  in  1  address fault, sampled with mem_ack.
- pc_load  in  1  redirect request.
- pc_new  in  DATA_WID  redirect target.
- icode, ifun, rA, rB  out  4 each  decoded fields.
- valC  out  DATA_WID  constant, little-endian assembled.
- valP  out  DATA_WID  address of the next sequential instruction.
- pc_out  out  DATA_WID  address of the presented instruction.
- instr_valid  out  1  instruction presented.
- instr_ready  in  1  decode accepts.
- instr_bad  out  1  icode > 0xB.
- imem_error  out  1  memory fault during this instruction.
- halted  out  1  sequencer stopped.

## Operation
- States: FETCH_OP, FETCH_REG, FETCH_C, PRESENT, HALTED.
- Reset: PC=RESET_PC, state FETCH_OP, byte counter 0. All outputs are 0, except mem_addr=RESET_PC and mem_req=1 from the first cycle after reset.
- FETCH_OP: request PC. On ack:
  - icode=rdata[7:4], ifun=rdata[3:0].
  - Set need_regids for icode 2,3,4,5,6,A,B.
  - Set need_valC for icode 3,4,5,7,8.
  - Next state: FETCH_REG if need_regids, else FETCH_C if need_valC, else PRESENT.
  - Invalid icode (C–F): instr_bad=1, go to PRESENT.
- FETCH_REG: request PC+1. On ack: rA=rdata[7:4], rB=rdata[3:0]. Go to FETCH_C if need_valC, else PRESENT.
- FETCH_C: request PC+1+need_regids+k for k=0..7. Byte k goes to valC[8k+7:8k]. After k=7 is acked, go to PRESENT.
- Fields not fetched (rA/rB, valC) read 0xF/0xF and 0 respectively.
- valP = PC + 1 + need_regids + 8·need_valC, modulo 2^DATA_WID. All address arithmetic wraps silently.
- PRESENT: instr_valid=1, outputs stable. On instr_valid&&instr_ready:
  - If icode=0 (halt), instr_bad, or imem_error: go to HALTED.
  - Else PC←valP, go to FETCH_OP.
- mem_err with ack in any fetch state: stop fetching, imem_error=1, go to PRESENT with fields captured so far.
- HALTED: halted=1, mem_req=0. Leaves only on pc_load.
- pc_load (priority over everything but rst), in any state:
  - PC←pc_new, state FETCH_OP, counter cleared, instr_valid/instr_bad/imem_error cleared next cycle.
  - A byte acked in the same cycle is discarded.
  - A simultaneous instr_ready handshake is ignored.
- rst mid-fetch abandons the outstanding request; the memory treats a dropped mem_req as a cancel.

## Timing
- A zero-wait memory (mem_ack in the same cycle as mem_req) delivers one byte per cycle.
- An n-byte instruction raises instr_valid n cycles after FETCH_OP is entered.
- After an accepted handshake, mem_req for the next opcode is asserted the following cycle: one bubble per instruction.
- Wait states stretch the current byte only. mem_addr never changes while mem_req=1 and mem_ack=0, except on pc_load or rst.
- The redirect target is requested the cycle after pc_load.

## Test plan
- Reset, memory {0x10 @0}, ready=1, zero-wait -> mem_req=1 addr 0 at cycle 1; instr_valid at cycle 2 with icode=1, valP=1, rA=rB=0xF; next request addr 1.
- irmovq {30 F3 08 07 06 05 04 03 02 01} @0 -> instr_valid after 10 acks; icode=3, rA=F, rB=3, valC=0x0102030405060708, valP=10.
- Halt 0x00 at 5 (PC redirected to 5) -> presented, then halted=1, mem_req=0 indefinitely; pc_load with pc_new=0 -> halted=0, request addr 0 next cycle.
- Byte 0xE0 -> instr_bad=1, valP=PC+1; after accept, halted=1. mem_err on byte 3 of a jXX -> imem_error=1, go to HALTED.
- pc_load with pc_new=0x40 during FETCH_C k=4, with ack the same cycle -> byte discarded; next mem_addr=0x40; no instr_valid for the aborted instruction.
- instr_ready=0 for 5 cycles on rrmovq {20 12} -> outputs held stable, mem_req=0; accepted on ready -> next fetch at valP=PC+2. Also PC=0xFFFF_FFFF_FFFF_FFFF with nop -> valP=0.
